// File: rtl/systolic_ctrl.sv
// Sequencer for a ROWS x COLS output-stationary systolic MAC array: clear, stream, skew, drain, hold.
// Optional drain watchdog enabled by defining SYSTOLIC_CTRL_TIMEOUT_EN.
module systolic_ctrl #(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COLS  = 4,
    parameter int unsigned K_MAX = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(K_MAX+1)-1:0] k_len,
    output logic                       busy,
    output logic                       rd_en,
    output logic [$clog2(K_MAX)-1:0]   rd_addr,
    input  logic [16*ROWS-1:0]         act_rd,
    input  logic [16*COLS-1:0]         wt_rd,
    output logic [16*ROWS-1:0]         act_left,
    output logic [16*COLS-1:0]         weight_top,
    output logic [ROWS-1:0]            input_done_row,
    output logic                       array_en,
    input  logic                       calc_done_corner,
    output logic                       result_valid,
    input  logic                       result_ack,
    output logic                       err
);

    localparam int unsigned LW = 16;
    localparam int unsigned KW = $clog2(K_MAX + 1);
    localparam int unsigned AW = $clog2(K_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] last_addr_q, last_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          rd_en_q, rd_en_d;
    logic          busy_q, busy_d;
    logic          array_en_q, array_en_d;
    logic          result_valid_q, result_valid_d;
    logic          valid0_q, valid0_d;
    logic          last0_q, last0_d;
    logic          k_ok;

`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(ROWS + COLS + 1);
    logic [TW-1:0] drain_cnt_q, drain_cnt_d;
    logic          err_q, err_d;
`endif

    assign k_ok = (k_len != '0) && (k_len <= KW'(K_MAX));

    // Next-state and registered-output decode; outputs follow the state being entered.
    always_comb begin
        state_d     = state_q;
        last_addr_d = last_addr_q;
        rd_addr_d   = '0;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
        drain_cnt_d = '0;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && k_ok) begin
                    last_addr_d = AW'(k_len - KW'(1));
                    state_d     = S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_STREAM;
            S_STREAM: begin
                if (rd_addr_q == last_addr_q) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_addr_d = rd_addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                if (calc_done_corner) begin
                    state_d = S_HOLD;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
                end else if (drain_cnt_q == TW'(ROWS + COLS)) begin
                    state_d = S_HOLD;
                    err_d   = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + TW'(1);
`endif
                end
            end
            S_HOLD: begin
                if (result_ack) begin
                    state_d = S_IDLE;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d         = (state_d != S_IDLE);
        rd_en_d        = (state_d == S_STREAM);
        array_en_d     = (state_d == S_STREAM) || (state_d == S_DRAIN) || (state_d == S_HOLD);
        result_valid_d = (state_d == S_HOLD);
    end

    // Read data lands one cycle after the strobe; track which beat is valid and last.
    always_comb begin
        valid0_d = rd_en_q;
        last0_d  = rd_en_q && (rd_addr_q == last_addr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            last_addr_q    <= '0;
            rd_addr_q      <= '0;
            rd_en_q        <= 1'b0;
            busy_q         <= 1'b0;
            array_en_q     <= 1'b0;
            result_valid_q <= 1'b0;
            valid0_q       <= 1'b0;
            last0_q        <= 1'b0;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
            drain_cnt_q    <= '0;
            err_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            last_addr_q    <= last_addr_d;
            rd_addr_q      <= rd_addr_d;
            rd_en_q        <= rd_en_d;
            busy_q         <= busy_d;
            array_en_q     <= array_en_d;
            result_valid_q <= result_valid_d;
            valid0_q       <= valid0_d;
            last0_q        <= last0_d;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
            drain_cnt_q    <= drain_cnt_d;
            err_q          <= err_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign array_en     = array_en_q;
    assign result_valid = result_valid_q;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Gate buffer data so empty skew stages carry zeros.
    logic [LW*ROWS-1:0] act_g;
    logic [LW*COLS-1:0] wt_g;
    assign act_g = valid0_q ? act_rd : '0;
    assign wt_g  = valid0_q ? wt_rd  : '0;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        if (r == 0) begin : g_edge
            assign act_left[LW-1:0]  = act_g[LW-1:0];
            assign input_done_row[0] = last0_q;
        end else begin : g_skew
            logic [r-1:0][LW-1:0] dat_q, dat_d;
            logic [r-1:0]         tag_q, tag_d;

            always_comb begin
                dat_d[0] = act_g[r*LW +: LW];
                tag_d[0] = last0_q;
                for (int s = 1; s < r; s++) begin
                    dat_d[s] = dat_q[s-1];
                    tag_d[s] = tag_q[s-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dat_q <= '0;
                    tag_q <= '0;
                end else begin
                    dat_q <= dat_d;
                    tag_q <= tag_d;
                end
            end

            assign act_left[r*LW +: LW] = dat_q[r-1];
            assign input_done_row[r]    = tag_q[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        if (c == 0) begin : g_edge
            assign weight_top[LW-1:0] = wt_g[LW-1:0];
        end else begin : g_skew
            logic [c-1:0][LW-1:0] dat_q, dat_d;

            always_comb begin
                dat_d[0] = wt_g[c*LW +: LW];
                for (int s = 1; s < c; s++) begin
                    dat_d[s] = dat_q[s-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dat_q <= '0;
                end else begin
                    dat_q <= dat_d;
                end
            end

            assign weight_top[c*LW +: LW] = dat_q[c-1];
        end
    end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencing controller for a ROWS x COLS output-stationary systolic array of 16-bit multiply-accumulate PEs. On `start`, it clears the array accumulators and reads `k_len` operand vectors from the activation and weight buffers. It skews each vector onto the array edges, with row r delayed by r cycles and column c by c cycles, and tags the last operand with `input_done`. It waits for the done tag to reach the bottom-right PE, then holds the accumulated sums stable until the consumer acknowledges them.

## Interface
- `ROWS`, 4, array rows (activation lanes)
- `COLS`, 4, array columns (weight lanes)
- `K_MAX`, 64, maximum reduction length; `KW = $clog2(K_MAX+1)`
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  launch request; sampled only in IDLE
- `k_len`  in  KW  reduction length, sampled with `start`
- `busy`  out  1  high in every state except IDLE
- `rd_en`  out  1  buffer read strobe; data returns the next cycle
- `rd_addr`  out  $clog2(K_MAX)  buffer read address
- `act_rd`  in  16*ROWS  activation vector from buffer (row 0 = LSBs)
- `wt_rd`  in  16*COLS  weight vector from buffer (col 0 = LSBs)
- `act_left`  out  16*ROWS  skewed activations to the array left edge
- `weight_top`  out  16*COLS  skewed weights to the array top edge
- `input_done_row`  out  ROWS  per-row last-operand tag, skewed with `act_left`
- `array_en`  out  1  PE enable; low clears all PE state
- `calc_done_corner`  in  1  `calc_done` output of PE[ROWS-1][COLS-1]
- `result_valid`  out  1  sums are final and held
- `result_ack`  in  1  consumer has read the sums
- `err`  out  1  drain timeout flag (see Configuration)

## Operation
- **FSM states:** IDLE, CLEAR, STREAM, DRAIN, HOLD.
- **IDLE:**
  - `array_en`=0.
  - `start`=1 with `k_len` in 1..K_MAX: latch `k_len` and go to CLEAR.
  - `k_len`=0 or `k_len`>K_MAX: `start` is ignored.
- **CLEAR:**
  - Lasts 1 cycle; `array_en`=0.
  - Go to STREAM.
- **STREAM:**
  - `array_en`=1.
  - `rd_en`=1 for exactly `k_len` cycles, with `rd_addr` = 0,1,…,`k_len`-1.
  - After the last read, go to DRAIN.
- **DRAIN:**
  - `array_en`=1.
  - Go to HOLD on the cycle after `calc_done_corner`=1.
- **HOLD:**
  - `array_en`=1, with zero operands driven so the sums stay constant.
  - `result_valid`=1.
  - `result_ack`=1 returns the FSM to IDLE; the next cycle `array_en`=0 clears the array.
- **Skew:** a valid read-data beat enters the skew network the cycle after `rd_en`.
  - Row r of `act_left` and `input_done_row[r]` are delayed by a further r registers.
  - Column c of `weight_top` is delayed by c registers.
- **Tag:** `input_done_row[r]`=1 only on the beat carrying operand `k_len`-1 for that row.
- **Zero fill:** all lanes and tags read 0 whenever no valid beat occupies that skew stage.
- **Ignored inputs:** `start` outside IDLE and `result_ack` outside HOLD have no effect.
- **Reset:**
  - `rst` forces IDLE at any point, including mid-operation.
  - All skew registers, counters and outputs go to 0: `busy`, `rd_en`, `rd_addr`, `act_left`, `weight_top`, `input_done_row`, `array_en`, `result_valid`, `err`.
  - After reset, a new `start` may be accepted on the first clock edge.

## Timing
- Cycle 0 is the cycle in which `start` is accepted.
- CLEAR is cycle 1.
- `rd_en` is high in cycles 2..`k_len`+1.
- Operand i is at row 0 / column 0 in cycle i+3, and at row r / column c edge in cycle i+3+r (resp. c).
- `calc_done_corner` is expected in cycle `k_len`+ROWS+COLS+1.
- `result_valid` rises the following cycle.
- `result_ack` in cycle t gives `result_valid`=0 and `busy`=0 in t+1, and `array_en`=0 in t+1.
- Earliest next `start` is in t+1; its CLEAR cycle is then t+2.
- Throughput: one operand vector per cycle, with no bubbles in STREAM.

## Configuration
- `SYSTOLIC_CTRL_TIMEOUT_EN` defined:
  - A drain watchdog counts cycles in DRAIN.
  - If `calc_done_corner` has not arrived after ROWS+COLS+1 DRAIN cycles, the FSM goes to HOLD with `err`=1.
  - `err` clears on `result_ack` or `rst`.
- Macro not defined:
  - DRAIN waits indefinitely for `calc_done_corner`.
  - `err` is tied to 0.

## Test plan
- **Single 4x4 run:** `k_len`=3, `start` at cycle 0, model array attached.
  - `rd_en` is high in cycles 2–4 with addresses 0,1,2.
  - `calc_done_corner` arrives in cycle 12 and `result_valid` rises in cycle 13.
  - Sums equal the A·B reference.
- **Skew check:** `act_rd` = 0x0101 in every lane, `k_len`=1.
  - `act_left` row 0 is nonzero only in cycle 3 and row 3 only in cycle 6.
  - `input_done_row[3]`=1 in cycle 6 only.
- **Back-to-back:**
  - `result_ack` in cycle 20 with `start` in cycle 21: `array_en` is 0 in cycles 21–22.
  - Second results carry no residue from the first run.
- **Ignored requests:**
  - `start` with `k_len`=0: `busy` stays 0 and `rd_en` never rises.
  - `start` during STREAM: no restart, and the address sequence is unchanged.
- **Reset mid-run:** `rst` pulse during DRAIN.
  - All outputs read 0 the same cycle.
  - A `start` after release runs normally.
- **Timeout (macro defined):** `calc_done_corner` held at 0 with `k_len`=2.
  - `err`=1 and `result_valid`=1 after 9 DRAIN cycles.
  - `result_ack` clears both.
